alu_seq: RTL

- Parametrised, registered successor to the 8-bit team ALU: WIDTH-bit operands, 4-bit opcode, 4-bit status register (sreg).
- Adds a start/busy/done handshake, carry-chained ops, compare, shifts, and iterative multi-cycle multiply and divide.
- Sits between the register file and the writeback stage of the datapath. One operation is in flight at a time.

---
 rtl/alu_seq.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle arithmetic/logic/shift ops, plus iterative
// multiply and divide behind a start/busy/done handshake.
module alu_seq #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       sreg,
  output logic             busy,
  output logic             done
);

  typedef enum logic [3:0] {
    OP_PASS  = 4'h0, OP_ADD   = 4'h1, OP_SUB  = 4'h2, OP_AND  = 4'h3,
    OP_OR    = 4'h4, OP_XOR   = 4'h5, OP_SHL  = 4'h6, OP_SHR  = 4'h7,
    OP_ASR   = 4'h8, OP_ADC   = 4'h9, OP_SBC  = 4'hA, OP_CMP  = 4'hB,
    OP_MULLO = 4'hC, OP_MULHI = 4'hD, OP_DIVQ = 4'hE, OP_DIVR = 4'hF
  } op_t;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, next_state;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [CNT_W-1:0]   cnt;
  logic               accept, is_multi, last_iter;

  assign busy      = (state == RUN);
  assign accept    = start && !busy;
  assign is_multi  = (op[3:2] == 2'b11);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept && is_multi) next_state = RUN;
      RUN:  if (last_iter)          next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Single-cycle datapath; extended vectors carry the carry/borrow or shifted-out bit.
  logic [CNT_W-1:0] amt;
  logic             amt_big, cin;
  logic [WIDTH:0]   add_ext, sub_ext, shl_ext, shr_ext, asr_ext;
  logic [WIDTH-1:0] sc_val;
  logic             sc_c, sc_v;
  logic [3:0]       sc_flags;

  assign amt     = b[CNT_W-1:0];
  assign amt_big = (amt >= CNT_W'(WIDTH));
  assign cin     = ((op == OP_ADC) || (op == OP_SBC)) && sreg[0];
  assign add_ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign sub_ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
  assign shl_ext = {1'b0, a} << amt;
  assign shr_ext = {a, 1'b0} >> amt;
  assign asr_ext = $signed({a, 1'b0}) >>> amt;

  always_comb begin
    sc_val = a;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        sc_val = add_ext[WIDTH-1:0];
        sc_c   = add_ext[WIDTH];
        sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_SBC, OP_CMP: begin
        sc_val = sub_ext[WIDTH-1:0];
        sc_c   = sub_ext[WIDTH];
        sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: sc_val = a & b;
      OP_OR:  sc_val = a | b;
      OP_XOR: sc_val = a ^ b;
      OP_SHL: begin
        if (amt_big) sc_val = '0;
        else begin
          sc_val = shl_ext[WIDTH-1:0];
          sc_c   = shl_ext[WIDTH];
        end
      end
      OP_SHR: begin
        if (amt_big) sc_val = '0;
        else begin
          sc_val = shr_ext[WIDTH:1];
          sc_c   = shr_ext[0];
        end
      end
      OP_ASR: begin
        if (amt_big) sc_val = {WIDTH{a[WIDTH-1]}};
        else begin
          sc_val = asr_ext[WIDTH:1];
          sc_c   = asr_ext[0];
        end
      end
      default: sc_val = a;
    endcase
  end

  assign sc_flags = {sc_v, sc_val[WIDTH-1], (sc_val == '0), sc_c};

  // acc is {high, low}: multiplier shifts out of low for MUL, {remainder, quotient} for DIV.
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] fin_val;
  logic [3:0]       fin_flags;

  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_q} : '0);
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_q};

  always_comb begin
    acc_next = {mul_sum, acc[WIDTH-1:1]};
    if (op_q[1]) begin
      if (div_diff[WIDTH]) acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else                 acc_next = {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
    end
  end

  assign fin_val   = op_q[0] ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];
  assign fin_flags = {op_q[1] && (b_q == '0), fin_val[WIDTH-1], (fin_val == '0),
                      !op_q[1] && (acc_next[2*WIDTH-1:WIDTH] != '0)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      sreg   <= '0;
      done   <= 1'b0;
      op_q   <= '0;
      b_q    <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        if (is_multi) begin
          op_q <= op[1:0];
          b_q  <= b;
          acc  <= {{WIDTH{1'b0}}, a};
          cnt  <= '0;
        end else begin
          if (op != OP_CMP) result <= sc_val;
          sreg <= sc_flags;
          done <= 1'b1;
        end
      end else if (busy) begin
        acc <= acc_next;
        cnt <= cnt + CNT_W'(1);
        if (last_iter) begin
          result <= fin_val;
          sreg   <= fin_flags;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule
